// File: rtl/oh_fifo_pkg.sv
// Shared helpers for the oh_fifo family: pointer sizing and parameter sanity checks.
package oh_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 4) && ((depth & (depth - 1)) == 0);
    endfunction

    function automatic bit prog_ok(input int depth, input int prog_full, input int prog_empty);
        return (prog_full <= depth) && (prog_empty < prog_full);
    endfunction

endpackage

// File: rtl/oh_fifo_fwft_stage.sv
// Output register with valid bit that prefetches the FIFO head for first-word-fall-through.
module oh_fifo_fwft_stage #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready
);

    // Handshake: a beat moves on a port at an edge where valid & ready are both high;
    // valid never depends on ready, and a stalled beat stays stable until taken.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/oh_memory_dp.sv
// Generic dual-port memory: one synchronous write port, one asynchronous read port.
module oh_memory_dp #(
    parameter int DW    = 64,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_din,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_dout
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_din;
    end

    assign rd_dout = mem[rd_addr];

endmodule

// File: rtl/oh_fifo_sync_fwft.sv
// Single-clock FIFO with true-DEPTH capacity, optional FWFT output, programmable thresholds,
// synchronous flush and sticky overflow/underflow flags.
module oh_fifo_sync_fwft
    import oh_fifo_pkg::*;
#(
    parameter int DW         = 64,
    parameter int DEPTH      = 32,
    parameter int FWFT       = 0,
    parameter int PROG_FULL  = DEPTH - 4,
    parameter int PROG_EMPTY = 2,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          wr_en,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          prog_full,
    output logic          empty,
    output logic          prog_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int         PW         = ptr_width(DEPTH);
    localparam bit         FWFT_B     = (FWFT != 0);
    localparam bit         DEPTH_OK   = depth_ok(DEPTH);
    localparam bit         PROG_OK    = prog_ok(DEPTH, PROG_FULL, PROG_EMPTY);
    localparam logic [AW:0] DEPTH_C   = PW'(DEPTH);
    localparam logic [AW:0] PFULL_C   = PW'(PROG_FULL);
    localparam logic [AW:0] PEMPTY_C  = PW'(PROG_EMPTY);

    if (!DEPTH_OK) begin : g_bad_depth
        $error("oh_fifo_sync_fwft: DEPTH must be a power of two and >= 4");
    end
    if (!PROG_OK) begin : g_bad_prog
        $error("oh_fifo_sync_fwft: need PROG_FULL <= DEPTH and PROG_EMPTY < PROG_FULL");
    end

    logic [AW:0]   wr_ptr, rd_ptr, mem_count;
    logic          mem_nonempty, mem_pop;
    logic          wr_acc, rd_acc;
    logic          stage_valid;
    logic [DW-1:0] mem_rd;

    assign mem_count    = wr_ptr - rd_ptr;
    assign mem_nonempty = (mem_count != '0);
    assign count        = mem_count + {{AW{1'b0}}, stage_valid};

    assign full       = (count == DEPTH_C);
    assign prog_full  = (count >= PFULL_C);
    assign prog_empty = (count <= PEMPTY_C);

    // In FWFT mode a read while full vacates the output register, so the write fits.
    assign rd_acc = rd_en & ~empty;
    assign wr_acc = wr_en & (~full | (FWFT_B & rd_acc));

    oh_memory_dp #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc & ~flush),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_din  (din),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_dout (mem_rd)
    );

    if (FWFT_B) begin : g_fwft
        logic stage_in_ready;

        oh_fifo_fwft_stage #(.DW(DW)) u_stage (
            .clk       (clk),
            .nreset    (nreset),
            .flush     (flush),
            .in_valid  (mem_nonempty),
            .in_data   (mem_rd),
            .in_ready  (stage_in_ready),
            .out_valid (stage_valid),
            .out_data  (dout),
            .out_ready (rd_en)
        );

        assign empty   = ~stage_valid;
        assign mem_pop = mem_nonempty & stage_in_ready;
    end else begin : g_std
        logic [DW-1:0] dout_r;

        always_ff @(posedge clk or negedge nreset) begin
            if (!nreset) begin
                dout_r <= '0;
            end else if (rd_acc && !flush) begin
                dout_r <= mem_rd;
            end
        end

        assign dout        = dout_r;
        assign stage_valid = 1'b0;
        assign empty       = ~mem_nonempty;
        assign mem_pop     = rd_acc;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc)              wr_ptr    <= wr_ptr + 1'b1;
            if (mem_pop)             rd_ptr    <= rd_ptr + 1'b1;
            if (wr_en && !wr_acc)    overflow  <= 1'b1;
            if (rd_en && !rd_acc)    underflow <= 1'b1;
        end
    end

endmodule
